// File: rtl/md_sched.sv
// Multiply/divide scheduler: owns HI/LO, runs fixed-latency mult/div operations,
// and stalls the D stage while an operation is in flight or starting.
module md_sched #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        md_use_d,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        done
);

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] DIV  = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      a_q, b_q;
  logic             sgn_q;

  logic [63:0] ext_a, ext_b, prod;
  logic [31:0] abs_a, abs_b, q_mag, r_mag, quo, rem;
  logic        div_zero;
  logic        accept_md;

  // Only a start seen in IDLE is taken; anything arriving while busy is dropped.
  assign accept_md = (state == IDLE) && start && !op[2];
  assign busy      = (state != IDLE);
  assign stall     = md_use_d & (busy | (start & ~op[2]));

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    ext_a    = sgn_q ? {{32{a_q[31]}}, a_q} : {32'h0, a_q};
    ext_b    = sgn_q ? {{32{b_q[31]}}, b_q} : {32'h0, b_q};
    // Low 64 bits of the product are the same whether the operands are signed or not.
    prod     = ext_a * ext_b;
    div_zero = (b_q == 32'h0);
    abs_a    = (sgn_q && a_q[31]) ? (32'h0 - a_q) : a_q;
    abs_b    = (sgn_q && b_q[31]) ? (32'h0 - b_q) : b_q;
    q_mag    = 32'h0;
    r_mag    = 32'h0;
    if (!div_zero) begin
      q_mag = abs_a / abs_b;
      r_mag = abs_a % abs_b;
    end
    // 0x80000000 / -1 falls out naturally: the magnitude negates back onto itself.
    quo = (sgn_q && (a_q[31] ^ b_q[31])) ? (32'h0 - q_mag) : q_mag;
    rem = (sgn_q && a_q[31]) ? (32'h0 - r_mag) : r_mag;
  end

  // NOTE: operand registers carry no reset; they are always written before being read.
  always_ff @(posedge clk) begin
    if (accept_md) begin
      a_q   <= a;
      b_q   <= b;
      sgn_q <= ~op[0];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      done  <= 1'b0;
      hi    <= 32'h0;
      lo    <= 32'h0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            case (op)
              3'd0, 3'd1: begin
                state <= MUL;
                cnt   <= MUL_LOAD;
              end
              3'd2, 3'd3: begin
                state <= DIV;
                cnt   <= DIV_LOAD;
              end
              3'd4:    hi <= a;
              3'd5:    lo <= a;
              default: ;
            endcase
          end
        end
        MUL, DIV: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            state <= IDLE;
            done  <= 1'b1;
            if (state == MUL) begin
              hi <= prod[63:32];
              lo <= prod[31:0];
            end else if (!div_zero) begin
              hi <= rem;
              lo <= quo;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_sched.sv
// Self-checking bench for md_sched: directed scenarios plus randomized traffic,
// all checked against a cycle-level reference model of the HI/LO unit.
module tb_md_sched;

  localparam int MUL_CYCLES = 5;
  localparam int DIV_CYCLES = 10;

  logic        clk = 1'b0;
  logic        reset, start, md_use_d;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, stall, done;
  logic [31:0] hi, lo;

  always #5 clk = ~clk;

  md_sched #(.MUL_CYCLES(MUL_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .md_use_d(md_use_d), .busy(busy), .stall(stall), .hi(hi), .lo(lo), .done(done)
  );

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model: remaining busy cycles plus the result waiting to land.
  int          m_left = 0;
  logic        m_done = 1'b0, m_wr = 1'b0;
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  logic        exp_stall, obs_stall;

  task automatic model_edge(input logic rst_v, input logic st, input logic [2:0] o,
                            input logic [31:0] av, input logic [31:0] bv);
    logic [63:0] pr;
    longint      q, r;
    if (!rst_v) begin
      m_left = 0; m_done = 1'b0; m_hi = '0; m_lo = '0;
    end else if (m_left > 0) begin
      m_left = m_left - 1;
      m_done = 1'b0;
      if (m_left == 0) begin
        if (m_wr) begin m_hi = p_hi; m_lo = p_lo; end
        m_done = 1'b1;
      end
    end else begin
      m_done = 1'b0;
      if (st) begin
        case (o)
          3'd0: begin
            pr = longint'($signed(av)) * longint'($signed(bv));
            {p_hi, p_lo} = pr; m_wr = 1'b1; m_left = MUL_CYCLES;
          end
          3'd1: begin
            pr = {32'h0, av} * {32'h0, bv};
            {p_hi, p_lo} = pr; m_wr = 1'b1; m_left = MUL_CYCLES;
          end
          3'd2: begin
            m_wr = (bv != 0); m_left = DIV_CYCLES;
            if (m_wr) begin
              q = longint'($signed(av)) / longint'($signed(bv));
              r = longint'($signed(av)) % longint'($signed(bv));
              p_lo = q[31:0]; p_hi = r[31:0];
            end
          end
          3'd3: begin
            m_wr = (bv != 0); m_left = DIV_CYCLES;
            if (m_wr) begin p_lo = av / bv; p_hi = av % bv; end
          end
          3'd4: m_hi = av;
          3'd5: m_lo = av;
          default: ;
        endcase
      end
    end
  endtask

  // Drives one cycle's inputs, samples stall before the edge, advances the model.
  task automatic tick(input logic rst_v, input logic st, input logic [2:0] o,
                      input logic [31:0] av, input logic [31:0] bv, input logic ud);
    reset = rst_v; start = st; op = o; a = av; b = bv; md_use_d = ud;
    #1;
    obs_stall = stall;
    exp_stall = ud & ((m_left > 0) | (st & (o < 3'd4)));
    @(posedge clk);
    model_edge(rst_v, st, o, av, bv);
    #1;
  endtask

  task automatic test_reset();
    tick(1'b0, 1'b0, 3'd7, '0, '0, 1'b0);
    tick(1'b0, 1'b1, 3'd4, 32'hDEAD_BEEF, '0, 1'b0);
    n_cmp++;
    if ({busy, done, hi, lo} !== {1'b0, 1'b0, 32'h0, 32'h0}) begin
      n_mis++;
      $display("FAIL reset_state: got busy=%b done=%b hi=%h lo=%h, want 0 0 0 0", busy, done, hi, lo);
    end
  endtask

  task automatic test_signed_mult();
    int nb = 0, nd = 0;
    tick(1'b1, 1'b1, 3'd0, 32'hFFFF_FFFD, 32'd5, 1'b0);
    for (int i = 0; i < 8; i++) begin
      nb += int'(busy); nd += int'(done);
      n_cmp++;
      if ({busy, done, hi, lo, obs_stall} !== {m_left > 0, m_done, m_hi, m_lo, exp_stall}) begin
        n_mis++;
        $display("FAIL mult_cycle%0d: got b=%b d=%b hi=%h lo=%h, want b=%b d=%b hi=%h lo=%h",
                 i, busy, done, hi, lo, m_left > 0, m_done, m_hi, m_lo);
      end
      tick(1'b1, 1'b0, 3'd0, '0, '0, 1'b0);
    end
    n_cmp++;
    if ({nb, nd, hi, lo} !== {32'd5, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFF1}) begin
      n_mis++;
      $display("FAIL mult_result: got busy_cycles=%0d done_pulses=%0d hi=%h lo=%h, want 5 1 ffffffff fffffff1",
               nb, nd, hi, lo);
    end
  endtask

  task automatic test_multu_ignore();
    tick(1'b1, 1'b1, 3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0);
    tick(1'b1, 1'b0, 3'd0, '0, '0, 1'b0);
    tick(1'b1, 1'b1, 3'd0, 32'd1, 32'd1, 1'b0);
    for (int i = 0; i < 6; i++) tick(1'b1, 1'b0, 3'd0, 32'd9, 32'd9, 1'b0);
    n_cmp++;
    if ({busy, hi, lo} !== {1'b0, 32'h0000_0001, 32'hFFFF_FFFE}) begin
      n_mis++;
      $display("FAIL multu_ignore: got busy=%b hi=%h lo=%h, want 0 00000001 fffffffe", busy, hi, lo);
    end
  endtask

  task automatic test_divide();
    int nb = 0, nd = 0;
    tick(1'b1, 1'b1, 3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
    for (int i = 0; i < 11; i++) tick(1'b1, 1'b0, 3'd0, '0, '0, 1'b0);
    n_cmp++;
    if ({hi, lo} !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin
      n_mis++;
      $display("FAIL div_signed: got hi=%h lo=%h, want ffffffff fffffffd", hi, lo);
    end
    tick(1'b1, 1'b1, 3'd3, 32'd7, 32'd0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      nb += int'(busy); nd += int'(done);
      tick(1'b1, 1'b0, 3'd0, '0, '0, 1'b0);
    end
    n_cmp++;
    if ({nb, nd, hi, lo} !== {32'd10, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin
      n_mis++;
      $display("FAIL divu_zero: got busy_cycles=%0d done_pulses=%0d hi=%h lo=%h, want 10 1 ffffffff fffffffd",
               nb, nd, hi, lo);
    end
    tick(1'b1, 1'b1, 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    for (int i = 0; i < 11; i++) tick(1'b1, 1'b0, 3'd0, '0, '0, 1'b0);
    n_cmp++;
    if ({hi, lo} !== {32'h0, 32'h8000_0000}) begin
      n_mis++;
      $display("FAIL div_overflow: got hi=%h lo=%h, want 00000000 80000000", hi, lo);
    end
  endtask

  task automatic test_move();
    tick(1'b1, 1'b1, 3'd4, 32'h1234_5678, '0, 1'b0);
    n_cmp++;
    if ({busy, done, hi} !== {1'b0, 1'b0, 32'h1234_5678}) begin
      n_mis++;
      $display("FAIL mthi_idle: got busy=%b done=%b hi=%h, want 0 0 12345678", busy, done, hi);
    end
    tick(1'b1, 1'b1, 3'd5, 32'hCAFE_0001, '0, 1'b0);
    n_cmp++;
    if (lo !== 32'hCAFE_0001) begin
      n_mis++;
      $display("FAIL mtlo_idle: got lo=%h, want cafe0001", lo);
    end
    tick(1'b1, 1'b1, 3'd1, 32'd3, 32'd4, 1'b0);
    tick(1'b1, 1'b1, 3'd4, 32'hAAAA_5555, '0, 1'b0);
    n_cmp++;
    if (hi !== 32'h1234_5678) begin
      n_mis++;
      $display("FAIL mthi_busy_hold: got hi=%h, want 12345678", hi);
    end
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 3'd0, '0, '0, 1'b0);
    n_cmp++;
    if ({hi, lo} !== {32'h0, 32'd12}) begin
      n_mis++;
      $display("FAIL mthi_busy_commit: got hi=%h lo=%h, want 00000000 0000000c", hi, lo);
    end
  endtask

  task automatic test_stall();
    int ns = 0;
    tick(1'b1, 1'b1, 3'd0, 32'd6, 32'd7, 1'b1);
    ns += int'(obs_stall);
    for (int i = 0; i < MUL_CYCLES; i++) begin
      tick(1'b1, 1'b0, 3'd0, '0, '0, 1'b1);
      ns += int'(obs_stall);
    end
    tick(1'b1, 1'b0, 3'd0, '0, '0, 1'b1);
    n_cmp++;
    if ({ns, done, obs_stall} !== {32'd6, 1'b0, 1'b0}) begin
      n_mis++;
      $display("FAIL stall_use: got stall_cycles=%0d done_cycle_stall=%b, want 6 0", ns, obs_stall);
    end
    ns = 0;
    tick(1'b1, 1'b1, 3'd2, 32'd60, 32'd7, 1'b0);
    ns += int'(obs_stall);
    for (int i = 0; i < DIV_CYCLES + 1; i++) begin
      tick(1'b1, 1'b0, 3'd0, '0, '0, 1'b0);
      ns += int'(obs_stall);
    end
    n_cmp++;
    if ({ns, hi, lo} !== {32'd0, 32'd4, 32'd8}) begin
      n_mis++;
      $display("FAIL stall_nouse: got stall_cycles=%0d hi=%h lo=%h, want 0 4 8", ns, hi, lo);
    end
  endtask

  task automatic test_back_to_back();
    tick(1'b1, 1'b1, 3'd0, 32'd2, 32'd3, 1'b0);
    for (int i = 0; i < MUL_CYCLES; i++) tick(1'b1, 1'b0, 3'd0, '0, '0, 1'b0);
    // done cycle: unit is idle, so this start is taken
    tick(1'b1, 1'b1, 3'd1, 32'd10, 32'd10, 1'b0);
    n_cmp++;
    if ({busy, done, lo} !== {1'b1, 1'b0, 32'd6}) begin
      n_mis++;
      $display("FAIL back_to_back_start: got busy=%b done=%b lo=%h, want 1 0 6", busy, done, lo);
    end
    for (int i = 0; i < MUL_CYCLES; i++) tick(1'b1, 1'b0, 3'd0, '0, '0, 1'b0);
    n_cmp++;
    if ({done, lo} !== {1'b1, 32'd100}) begin
      n_mis++;
      $display("FAIL back_to_back_result: got done=%b lo=%h, want 1 64", done, lo);
    end
  endtask

  task automatic test_reset_mid();
    int nd = 0;
    tick(1'b1, 1'b1, 3'd4, 32'h5555_0000, '0, 1'b0);
    tick(1'b1, 1'b1, 3'd2, 32'd100, 32'd3, 1'b0);
    tick(1'b1, 1'b0, 3'd0, '0, '0, 1'b0);
    tick(1'b1, 1'b0, 3'd0, '0, '0, 1'b0);
    tick(1'b0, 1'b0, 3'd0, '0, '0, 1'b0);
    n_cmp++;
    if ({busy, done, hi, lo} !== {1'b0, 1'b0, 32'h0, 32'h0}) begin
      n_mis++;
      $display("FAIL reset_mid: got busy=%b done=%b hi=%h lo=%h, want 0 0 0 0", busy, done, hi, lo);
    end
    for (int i = 0; i < DIV_CYCLES + 2; i++) begin
      tick(1'b1, 1'b0, 3'd0, '0, '0, 1'b0);
      nd += int'(done | busy);
    end
    n_cmp++;
    if ({nd, hi, lo} !== {32'd0, 32'h0, 32'h0}) begin
      n_mis++;
      $display("FAIL reset_no_commit: got busy_or_done=%0d hi=%h lo=%h, want 0 0 0", nd, hi, lo);
    end
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h0;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom();
    endcase
  endfunction

  task automatic test_random();
    logic        rv, st, ud;
    logic [2:0]  o;
    logic [31:0] av, bv;
    for (int i = 0; i < 600; i++) begin
      rv = ($urandom_range(0, 99) != 0);
      st = ($urandom_range(0, 2) == 0);
      ud = $urandom_range(0, 1) == 1;
      o  = 3'($urandom_range(0, 7));
      av = pick_operand();
      bv = pick_operand();
      tick(rv, st, o, av, bv, ud);
      n_cmp++;
      if ({busy, done, hi, lo, obs_stall} !== {m_left > 0, m_done, m_hi, m_lo, exp_stall}) begin
        n_mis++;
        $display("FAIL random_cycle%0d: got b=%b d=%b hi=%h lo=%h s=%b, want b=%b d=%b hi=%h lo=%h s=%b",
                 i, busy, done, hi, lo, obs_stall, m_left > 0, m_done, m_hi, m_lo, exp_stall);
      end
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; op = 3'd7; a = '0; b = '0; md_use_d = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_signed_mult();
    test_multu_ignore();
    test_divide();
    test_move();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
